// File: rtl/nibbler_pkg.sv
// Nibbler 4-bit CPU: shared opcodes, ALU select codes and sequencer states.
package nibbler_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ADDM  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_SUBM  = 4'h4;
    localparam logic [3:0] OP_NANDI = 4'h5;
    localparam logic [3:0] OP_NANDM = 4'h6;
    localparam logic [3:0] OP_LIT   = 4'h7;
    localparam logic [3:0] OP_LD    = 4'h8;
    localparam logic [3:0] OP_ST    = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JC    = 4'hC;
    localparam logic [3:0] OP_JNC   = 4'hD;
    localparam logic [3:0] OP_JZ    = 4'hE;
    localparam logic [3:0] OP_JNZ   = 4'hF;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        JADDR = 2'd2
    } state_t;

    function automatic logic is_jump(input logic [3:0] op);
        return op >= OP_JMP;
    endfunction

endpackage

// File: rtl/nibbler_ctrl_decode.sv
// Nibbler control decode: per-instruction strobes and jump condition.
// Purely combinational; everything is gated by en and the current state.
module nibbler_ctrl_decode
    import nibbler_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] instr,
    input  logic       C_flag,
    input  logic       Z_flag,
    input  logic       en,
    output logic [1:0] alu_sel,
    output logic       src_mem,
    output logic       acc_en,
    output logic       flags_en,
    output logic       mem_we,
    output logic       out_en,
    output logic       jump_cond
);

    always_comb begin
        alu_sel   = ALU_ADD;
        src_mem   = 1'b0;
        acc_en    = 1'b0;
        flags_en  = 1'b0;
        mem_we    = 1'b0;
        out_en    = 1'b0;
        jump_cond = 1'b0;
        if (en && state == EXEC) begin
            case (instr)
                OP_ADDI: begin
                    acc_en   = 1'b1;
                    flags_en = 1'b1;
                end
                OP_ADDM: begin
                    acc_en   = 1'b1;
                    flags_en = 1'b1;
                    src_mem  = 1'b1;
                end
                OP_SUBI: begin
                    acc_en   = 1'b1;
                    flags_en = 1'b1;
                    alu_sel  = ALU_SUB;
                end
                OP_SUBM: begin
                    acc_en   = 1'b1;
                    flags_en = 1'b1;
                    alu_sel  = ALU_SUB;
                    src_mem  = 1'b1;
                end
                OP_NANDI: begin
                    acc_en   = 1'b1;
                    flags_en = 1'b1;
                    alu_sel  = ALU_NAND;
                end
                OP_NANDM: begin
                    acc_en   = 1'b1;
                    flags_en = 1'b1;
                    alu_sel  = ALU_NAND;
                    src_mem  = 1'b1;
                end
                OP_LIT: begin
                    acc_en  = 1'b1;
                    alu_sel = ALU_PASS;
                end
                OP_LD: begin
                    acc_en  = 1'b1;
                    alu_sel = ALU_PASS;
                    src_mem = 1'b1;
                end
                OP_ST:   mem_we = 1'b1;
                OP_OUT:  out_en = 1'b1;
                default: ;
            endcase
        end else if (en && state == JADDR) begin
            case (instr)
                OP_JMP:  jump_cond = 1'b1;
                OP_JC:   jump_cond = C_flag;
                OP_JNC:  jump_cond = ~C_flag;
                OP_JZ:   jump_cond = Z_flag;
                OP_JNZ:  jump_cond = ~Z_flag;
                default: jump_cond = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/nibbler_sequencer.sv
// Nibbler fetch/execute sequencer: owns pc, the fetch latch and the phase FSM.
// Jumps are two-byte; the address byte is consumed in JADDR.
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [7:0]      prog_byte,
    input  logic            rom_valid,
    input  logic            C_flag,
    input  logic            Z_flag,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      instr,
    output logic [3:0]      oprnd,
    output logic [1:0]      alu_sel,
    output logic            src_mem,
    output logic            acc_en,
    output logic            flags_en,
    output logic            mem_we,
    output logic            out_en,
    output logic            jump_taken
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_instr;
    logic [3:0]      r_oprnd;

    state_t          w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic [3:0]      w_instr_nxt;
    logic [3:0]      w_oprnd_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic            w_fire;
    logic            w_jump_cond;

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = PC_W'({r_oprnd, prog_byte});
    assign w_fire   = en & rom_valid;

    nibbler_ctrl_decode u_dec (
        .state     (r_state),
        .instr     (r_instr),
        .C_flag    (C_flag),
        .Z_flag    (Z_flag),
        .en        (en),
        .alu_sel   (alu_sel),
        .src_mem   (src_mem),
        .acc_en    (acc_en),
        .flags_en  (flags_en),
        .mem_we    (mem_we),
        .out_en    (out_en),
        .jump_cond (w_jump_cond)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_oprnd_nxt = r_oprnd;
        unique case (r_state)
            FETCH: begin
                if (w_fire) begin
                    w_instr_nxt = prog_byte[7:4];
                    w_oprnd_nxt = prog_byte[3:0];
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = is_jump(prog_byte[7:4]) ? JADDR : EXEC;
                end
            end
            EXEC: begin
                if (en) w_state_nxt = FETCH;
            end
            JADDR: begin
                if (w_fire) begin
                    w_pc_nxt    = w_jump_cond ? w_target : w_pc_inc;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_oprnd <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_oprnd <= w_oprnd_nxt;
        end
    end

    // w_jump_cond is already qualified by en and JADDR
    assign jump_taken = w_jump_cond & rom_valid;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign oprnd      = r_oprnd;

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer with a behavioural program ROM.
module tb_nibbler_sequencer;

    logic        clk;
    logic        reset;
    logic        en;
    logic [7:0]  prog_byte;
    logic        rom_valid;
    logic        C_flag;
    logic        Z_flag;
    logic [11:0] pc;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [1:0]  alu_sel;
    logic        src_mem;
    logic        acc_en;
    logic        flags_en;
    logic        mem_we;
    logic        out_en;
    logic        jump_taken;

    logic [7:0]  rom [4096];
    logic [6:0]  stb;
    int          n_vec = 0;
    int          n_err = 0;

    nibbler_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .prog_byte  (prog_byte),
        .rom_valid  (rom_valid),
        .C_flag     (C_flag),
        .Z_flag     (Z_flag),
        .pc         (pc),
        .instr      (instr),
        .oprnd      (oprnd),
        .alu_sel    (alu_sel),
        .src_mem    (src_mem),
        .acc_en     (acc_en),
        .flags_en   (flags_en),
        .mem_we     (mem_we),
        .out_en     (out_en),
        .jump_taken (jump_taken)
    );

    assign prog_byte = rom[pc];
    assign stb = {acc_en, flags_en, mem_we, out_en, alu_sel, src_mem};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_jc(input logic c, input logic [11:0] exp_pc,
                          input logic exp_jt);
        clear_rom();
        rom[12'h000] = 8'hB0;
        rom[12'h001] = 8'h10;
        rom[12'h010] = 8'hC2;
        rom[12'h011] = 8'h34;
        C_flag = c;
        rom_valid = 1'b1;
        en = 1'b1;
        do_reset();
        step();
        chk("jmp_jt", 16'(jump_taken), 16'd1);
        step();
        chk("jmp_pc", 16'(pc), 16'h010);
        chk("jmp_jt_end", 16'(jump_taken), 16'd0);
        step();
        chk("jc_instr", 16'(instr), 16'hC);
        chk("jc_stb", 16'(stb), 16'd0);
        chk("jc_jt", 16'(jump_taken), 16'(exp_jt));
        step();
        chk("jc_pc", 16'(pc), 16'(exp_pc));
        chk("jc_jt_end", 16'(jump_taken), 16'd0);
    endtask

    logic [7:0] seq_byte [10];
    logic [6:0] seq_exp  [10];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        en = 1'b1;
        rom_valid = 1'b0;
        C_flag = 1'b0;
        Z_flag = 1'b0;
        clear_rom();
        rom[12'h000] = 8'h13;
        #1 reset = 1'b0;
        #1;
        chk("rst_pc", 16'(pc), 16'h000);
        chk("rst_instr", 16'(instr), 16'h0);
        chk("rst_stb", 16'(stb), 16'd0);
        chk("rst_jt", 16'(jump_taken), 16'd0);

        // ADDI 3, then an asynchronous reset in the middle of EXEC
        rom_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("addi_pc", 16'(pc), 16'h001);
        chk("addi_op", 16'({instr, oprnd}), 16'h13);
        chk("addi_stb", 16'(stb), 16'(7'b1100000));
        #3 reset = 1'b0;
        #1;
        chk("async_pc", 16'(pc), 16'h000);
        chk("async_op", 16'({instr, oprnd}), 16'h00);
        chk("async_stb", 16'(stb), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("refetch_pc", 16'(pc), 16'h001);
        chk("refetch_stb", 16'(stb), 16'(7'b1100000));

        run_jc(1'b1, 12'h234, 1'b1);
        run_jc(1'b0, 12'h012, 1'b0);

        // JNZ at 0xFFF takes its address byte from 0x000
        clear_rom();
        rom[12'h001] = 8'hBF;
        rom[12'h002] = 8'hFF;
        rom[12'hFFF] = 8'hF0;
        Z_flag = 1'b0;
        rom_valid = 1'b1;
        en = 1'b1;
        do_reset();
        step();
        step();
        step();
        step();
        chk("wrap_pre_pc", 16'(pc), 16'hFFF);
        step();
        chk("wrap_pc", 16'(pc), 16'h000);
        chk("wrap_instr", 16'(instr), 16'hF);
        chk("wrap_jt", 16'(jump_taken), 16'd1);
        step();
        chk("wrap_tgt", 16'(pc), 16'h000);
        chk("wrap_jt_end", 16'(jump_taken), 16'd0);

        // rom_valid stall in FETCH, then en=0 in EXEC of ST
        clear_rom();
        rom[12'h000] = 8'h95;
        rom_valid = 1'b0;
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 16'(pc), 16'h000);
            chk("stall_stb", 16'(stb), 16'd0);
        end
        rom_valid = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        #1;
        chk("st_pc", 16'(pc), 16'h001);
        chk("st_instr", 16'(instr), 16'h9);
        chk("st_hold_stb", 16'(stb), 16'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_pc", 16'(pc), 16'h001);
            chk("hold_stb", 16'(stb), 16'd0);
        end
        en = 1'b1;
        #1;
        chk("st_we", 16'(stb), 16'(7'b0010000));
        rom_valid = 1'b0;
        step();
        chk("st_we_end", 16'(stb), 16'd0);
        chk("st_pc_end", 16'(pc), 16'h001);

        // {acc_en, flags_en, mem_we, out_en, alu_sel, src_mem}
        seq_byte = '{8'h77, 8'hA0, 8'h95, 8'h85, 8'h21,
                     8'h32, 8'h43, 8'h54, 8'h65, 8'h00};
        seq_exp  = '{7'b1000110, 7'b0001000, 7'b0010000, 7'b1000111,
                     7'b1100001, 7'b1100010, 7'b1100011, 7'b1100100,
                     7'b1100101, 7'b0000000};
        clear_rom();
        for (int i = 0; i < 10; i++) rom[i] = seq_byte[i];
        rom_valid = 1'b1;
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("seq%0d_stb", i), 16'(stb), 16'(seq_exp[i]));
            chk($sformatf("seq%0d_pc", i), 16'(pc), 16'(i + 1));
            step();
            chk($sformatf("seq%0d_idle", i), 16'(stb), 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nibbler_sequencer.md
Name: nibbler_sequencer

Overview:
Fetch/execute sequencer for the Nibbler 4-bit CPU. Sits directly downstream of the C/Z flags register and consumes its registered C and Z outputs to resolve conditional jumps. It owns the 12-bit program counter and the fetch/execute phase. It generates the per-instruction enables, including the flags register enable, the accumulator load, the memory write and the output-port write.

Parameters:
PC_W, 12, program counter width; increments wrap modulo 2^PC_W.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
en  in  1  run enable; 0 freezes all state.
prog_byte  in  8  program ROM data at address pc.
rom_valid  in  1  prog_byte is valid this cycle.
C_flag  in  1  registered carry from the flags register.
Z_flag  in  1  registered zero from the flags register.
pc  out  PC_W  program ROM address.
instr  out  4  latched opcode nibble.
oprnd  out  4  latched operand nibble (immediate / memory address low).
alu_sel  out  2  00 add, 01 sub, 10 nand, 11 pass.
src_mem  out  1  1 = ALU B operand from data memory, 0 = oprnd.
acc_en  out  1  accumulator load strobe.
flags_en  out  1  flags register enable.
mem_we  out  1  data memory write strobe.
out_en  out  1  output port write strobe.
jump_taken  out  1  one-cycle pulse when a jump loads pc.

Behaviour:
- Opcodes (instr):
  - 0 NOP.
  - 1 ADDI, 2 ADDM, 3 SUBI, 4 SUBM, 5 NANDI, 6 NANDM.
  - 7 LIT (acc<=oprnd, pass).
  - 8 LD (pass, mem).
  - 9 ST.
  - A OUT.
  - B JMP, C JC, D JNC, E JZ, F JNZ.
- Jumps (B-F) are two bytes. Target = {oprnd, second byte}.
- States: FETCH, EXEC, JADDR. State is registered. All strobes are decoded combinationally from state and instr, and are 0 outside EXEC/JADDR.
- FETCH:
  - Waits for rom_valid & en.
  - On that cycle: instr<=prog_byte[7:4], oprnd<=prog_byte[3:0], pc<=pc+1.
  - Next state is JADDR if the opcode is >= B, else EXEC.
- EXEC (exactly one cycle when en=1), then FETCH:
  - ALU ops 1-6: acc_en=1, flags_en=1. alu_sel is add/sub/nand. src_mem=1 for even opcodes 2/4/6.
  - LIT: acc_en=1, alu_sel=11, src_mem=0, flags_en=0.
  - LD: acc_en=1, alu_sel=11, src_mem=1, flags_en=0.
  - ST: mem_we=1.
  - OUT: out_en=1.
  - NOP: no strobes.
- JADDR:
  - Waits for rom_valid & en.
  - Condition: JMP=1, JC=C_flag, JNC=~C_flag, JZ=Z_flag, JNZ=~Z_flag, sampled on that cycle.
  - Taken: pc<={oprnd,prog_byte}, jump_taken=1 for that cycle.
  - Not taken: pc<=pc+1.
  - Next state FETCH.
- Latency:
  - Non-jump instruction = 2 cycles (FETCH+EXEC) with rom_valid held high.
  - Jump = 2 cycles (FETCH+JADDR).
- Flag hazard: none. A flags_en edge in EXEC is always at least 2 cycles before the next JADDR evaluation.
- en=0: state, pc, instr and oprnd hold; all strobes and jump_taken are forced to 0. When en returns to 1, operation resumes in the same state.
- rom_valid=0 in FETCH/JADDR: the sequencer stalls; no pc change, no strobes.
- Wrap-around: pc=0xFFF increments to 0x000. A jump opcode at 0xFFF takes its address byte from 0x000.
- Reset (reset=0, any state, mid-instruction included):
  - pc=RESET_PC, state=FETCH, instr=0, oprnd=0.
  - All strobes and jump_taken are 0.
  - Reset takes effect immediately, asynchronously.
  - Release is synchronous to the next posedge.

Decomposition:
- Package nibbler_pkg holds:
  - opcode constants OP_NOP..OP_JNZ;
  - alu_sel encodings ALU_ADD/SUB/NAND/PASS;
  - the state enum (FETCH/EXEC/JADDR).
- One sub-module: nibbler_ctrl_decode, purely combinational. It maps (state, instr, C_flag, Z_flag, en) to the strobes, alu_sel, src_mem and jump condition.
- The FSM, PC and fetch latch stay in the top module.

Test Plan:
- Reset pulse mid-EXEC of ADDI -> all outputs 0 at once, pc=0x000, next posedge (released) shows state FETCH.
- ROM 0x13 at 0x000, rom_valid=1 -> cycle 1 pc=0x001 instr=1 oprnd=3; cycle 2 acc_en=1 flags_en=1 alu_sel=00 src_mem=0.
- C_flag=1, ROM 0xC2,0x34 at 0x010 -> after JADDR pc=0x234 with jump_taken pulsed once. Repeat with C_flag=0 -> pc=0x012, jump_taken=0.
- JNZ 0xF0,0x00 at 0xFFF with Z_flag=0 -> second byte read at pc=0x000; pc becomes 0x000 and jump_taken=1.
- rom_valid=0 for 3 cycles in FETCH, then en=0 for 2 cycles in EXEC of ST -> pc and state frozen, mem_we=0 while en=0, mem_we=1 for exactly one cycle after en returns.
- Sequence LIT 7, OUT, ST 5, LD 5 -> respectively acc_en with alu_sel=11/src_mem=0; out_en; mem_we; acc_en with src_mem=1. flags_en never asserted.
